// File: rtl/outarb_pkg.sv
// Shared widths, flit type codes and FSM state codes for the output arbiter.
// Flit layout: [FLOWBH:FLOWBL] is the flit type, the rest is payload.
package outarb_pkg;

   localparam int PKTW   = 17;
   localparam int FLITW  = PKTW + 1;
   localparam int PORT   = 3;
   localparam int FLOWBH = 17;
   localparam int FLOWBL = 16;

   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b10;
   localparam logic [1:0] TAIL = 2'b11;

   typedef enum logic {
      OA_IDLE = 1'b0,
      OA_BUSY = 1'b1
   } oa_state_t;

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/rrarb.sv
// Combinational 4-way arbiter: round-robin from ptr+1 when OUTARB_RR_EN is
// defined, otherwise a fixed-priority encoder with port 0 highest.
module rrarb (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] win
);

`ifdef OUTARB_RR_EN
   logic [1:0] idx;

   always_comb begin
      win = '0;
      idx = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (win == '0 && req[idx]) begin
            win[idx] = 1'b1;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Isolate the lowest set bit.
   assign win = req & (~req + 4'd1);
`endif

endmodule

// File: rtl/outarb.sv
// Output-port arbiter and flit forwarder: grants one input per packet and
// streams its flits HEAD..TAIL to a registered output. Define OUTARB_RR_EN for round-robin.
module outarb
   import outarb_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PORT:0]           reqi,
   input  logic [4*(PKTW+1)-1:0]   pkti,
   input  logic [PORT:0]           vldi,
   input  logic                    rdy,
   output logic [PORT:0]           gnt,
   output logic [PORT:0]           deq,
   output logic [PKTW:0]           pkto,
   output logic                    vldo
);

   oa_state_t        state_q, state_d;
   logic [PORT:0]    gnt_q, gnt_d;
   logic [PORT:0]    win;
   logic [PKTW:0]    pkto_q, pkto_d;
   logic             vldo_q, vldo_d;
   logic [PKTW:0]    fwd_flit;
   logic [FLITW-1:0] slice [PORT+1];
   logic [1:0]       ptr_q;
`ifdef OUTARB_RR_EN
   logic [1:0]       ptr_d;
`else
   assign ptr_q = 2'd3;
`endif

   generate
      for (genvar gi = 0; gi <= PORT; gi++) begin : g_slice
         assign slice[gi] = pkti[gi*FLITW +: FLITW];
      end
   endgenerate

   // gnt_q clears asynchronously on rst, so no flit can pop during reset.
   assign deq = gnt_q & vldi & {(PORT+1){rdy}};

   always_comb begin
      fwd_flit = '0;
      for (int i = 0; i <= PORT; i++) begin
         if (deq[i]) begin
            fwd_flit = fwd_flit | slice[i];
         end
      end
   end

   rrarb u_rrarb (
      .req (reqi),
      .ptr (ptr_q),
      .win (win)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      pkto_d  = pkto_q;
      vldo_d  = 1'b0;
`ifdef OUTARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         OA_IDLE: begin
            if (|reqi) begin
               gnt_d   = win;
               state_d = OA_BUSY;
            end
         end
         OA_BUSY: begin
            if (|deq) begin
               pkto_d = fwd_flit;
               vldo_d = 1'b1;
               if (fwd_flit[FLOWBH:FLOWBL] == TAIL) begin
                  gnt_d   = '0;
                  state_d = OA_IDLE;
`ifdef OUTARB_RR_EN
                  ptr_d   = onehot_idx(gnt_q);
`endif
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OA_IDLE;
         gnt_q   <= '0;
         pkto_q  <= '0;
         vldo_q  <= 1'b0;
`ifdef OUTARB_RR_EN
         ptr_q   <= 2'd3;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         pkto_q  <= pkto_d;
         vldo_q  <= vldo_d;
`ifdef OUTARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign pkto = pkto_q;
   assign vldo = vldo_q;

endmodule

// File: tb/tb_outarb.sv
// Directed bench for outarb: single packet, backpressure, underrun,
// TAIL-plus-request, async reset mid-packet and arbitration order.
module tb_outarb;
   import outarb_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [PORT:0]         reqi;
   logic [4*FLITW-1:0]    pkti;
   logic [PORT:0]         vldi;
   logic                  rdy;
   logic [PORT:0]         gnt;
   logic [PORT:0]         deq;
   logic [PKTW:0]         pkto;
   logic                  vldo;

   int checks = 0;
   int errors = 0;
   int order [5];

   outarb dut (
      .clk  (clk),
      .rst  (rst),
      .reqi (reqi),
      .pkti (pkti),
      .vldi (vldi),
      .rdy  (rdy),
      .gnt  (gnt),
      .deq  (deq),
      .pkto (pkto),
      .vldo (vldo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s %h", tag, got);
      end
   endtask

   function automatic logic [31:0] fl(input logic [1:0] t, input logic [15:0] p);
      return {14'd0, t, p};
   endfunction

   task automatic put(input int p, input logic [31:0] f);
      pkti[p*FLITW +: FLITW] = f[FLITW-1:0];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef OUTARB_RR_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 0, 0};
`endif
      rst  = 1'b1;
      pkti = '0;
      reqi = 4'hf;
      vldi = 4'hf;
      rdy  = 1'b1;
      for (int p = 0; p < 4; p++) put(p, fl(HEAD, 16'h0100));

      // Reset: nothing granted or popped even with every input active.
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_deq", 32'(deq), 0);
      check("rst_vldo", 32'(vldo), 0);
      check("rst_pkto", 32'(pkto), 0);
      reqi = '0; vldi = '0; rst = 1'b0;

      // Single requester, port 2, HEAD/BODY/TAIL.
      put(2, fl(HEAD, 16'hA001)); reqi = 4'b0100; vldi = 4'b0100;
      #1 check("t1_deq_idle", 32'(deq), 0);
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'b0100);
      check("t1_vldo0", 32'(vldo), 0);
      #1 check("t1_deq_head", 32'(deq), 32'b0100);
      @(negedge clk);
      check("t1_pkto_head", 32'(pkto), fl(HEAD, 16'hA001));
      check("t1_vldo_head", 32'(vldo), 1);
      reqi = '0; put(2, fl(BODY, 16'hA002));
      @(negedge clk);
      check("t1_pkto_body", 32'(pkto), fl(BODY, 16'hA002));
      check("t1_gnt_hold", 32'(gnt), 32'b0100);
      put(2, fl(TAIL, 16'hA003));
      @(negedge clk);
      check("t1_pkto_tail", 32'(pkto), fl(TAIL, 16'hA003));
      check("t1_vldo_tail", 32'(vldo), 1);
      check("t1_gnt_rel", 32'(gnt), 0);
      vldi = '0;
      @(negedge clk);
      check("t1_vldo_end", 32'(vldo), 0);
      check("t1_pkto_keep", 32'(pkto), fl(TAIL, 16'hA003));

      // Backpressure on port 1: rdy low for three cycles before BODY.
      put(1, fl(HEAD, 16'hB001)); reqi = 4'b0010; vldi = 4'b0010;
      @(negedge clk);
      check("bp_gnt", 32'(gnt), 32'b0010);
      @(negedge clk);
      check("bp_pkto_head", 32'(pkto), fl(HEAD, 16'hB001));
      reqi = '0; put(1, fl(BODY, 16'hB002)); rdy = 1'b0;
      #1 check("bp_deq_stall", 32'(deq), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_vldo", 32'(vldo), 0);
         check("bp_pkto", 32'(pkto), fl(HEAD, 16'hB001));
         check("bp_gnt_hold", 32'(gnt), 32'b0010);
         if (i == 2) rdy = 1'b1;
         #1 check("bp_deq", 32'(deq), (i == 2) ? 32'b0010 : 32'b0);
      end
      @(negedge clk);
      check("bp_pkto_body", 32'(pkto), fl(BODY, 16'hB002));
      check("bp_vldo_body", 32'(vldo), 1);
      put(1, fl(TAIL, 16'hB003));
      @(negedge clk);
      check("bp_pkto_tail", 32'(pkto), fl(TAIL, 16'hB003));
      check("bp_gnt_rel", 32'(gnt), 0);
      vldi = '0;

      // FIFO underrun on port 3 between BODY and TAIL.
      put(3, fl(HEAD, 16'hC001)); reqi = 4'b1000; vldi = 4'b1000;
      @(negedge clk);
      check("ur_gnt", 32'(gnt), 32'b1000);
      @(negedge clk);
      check("ur_pkto_head", 32'(pkto), fl(HEAD, 16'hC001));
      reqi = '0; put(3, fl(BODY, 16'hC002));
      @(negedge clk);
      check("ur_pkto_body", 32'(pkto), fl(BODY, 16'hC002));
      vldi = '0;
      #1 check("ur_deq_empty", 32'(deq), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("ur_vldo", 32'(vldo), 0);
         check("ur_gnt_hold", 32'(gnt), 32'b1000);
         check("ur_pkto", 32'(pkto), fl(BODY, 16'hC002));
         if (i == 1) begin
            vldi = 4'b1000; put(3, fl(TAIL, 16'hC003));
         end
      end
      @(negedge clk);
      check("ur_pkto_tail", 32'(pkto), fl(TAIL, 16'hC003));
      check("ur_vldo_tail", 32'(vldo), 1);
      check("ur_gnt_rel", 32'(gnt), 0);
      vldi = '0;

      // Port 0 TAIL pops while port 1 raises its request.
      put(0, fl(HEAD, 16'hD001)); reqi = 4'b0001; vldi = 4'b0001;
      @(negedge clk);
      check("tn_gnt0", 32'(gnt), 32'b0001);
      @(negedge clk);
      check("tn_pkto_head", 32'(pkto), fl(HEAD, 16'hD001));
      put(0, fl(TAIL, 16'hD002)); reqi = 4'b0010; put(1, fl(HEAD, 16'hE001)); vldi = 4'b0011;
      #1 check("tn_deq_tail", 32'(deq), 32'b0001);
      @(negedge clk);
      check("tn_bubble", 32'(gnt), 0);
      check("tn_pkto_tail", 32'(pkto), fl(TAIL, 16'hD002));
      vldi = 4'b0010;
      #1 check("tn_deq_bubble", 32'(deq), 0);
      @(negedge clk);
      check("tn_gnt1", 32'(gnt), 32'b0010);
      check("tn_vldo_bubble", 32'(vldo), 0);
      reqi = '0;
      @(negedge clk);
      check("tn_pkto_e1", 32'(pkto), fl(HEAD, 16'hE001));
      put(1, fl(TAIL, 16'hE002));
      @(negedge clk);
      check("tn_pkto_e2", 32'(pkto), fl(TAIL, 16'hE002));
      check("tn_gnt_rel", 32'(gnt), 0);
      vldi = '0;

      // Asynchronous reset pulsed between edges mid-packet.
      put(2, fl(HEAD, 16'hF001)); reqi = 4'b0100; vldi = 4'b0100;
      @(negedge clk);
      check("ar_gnt", 32'(gnt), 32'b0100);
      @(negedge clk);
      check("ar_pkto_head", 32'(pkto), fl(HEAD, 16'hF001));
      reqi = '0; put(2, fl(BODY, 16'hF002));
      #2 rst = 1'b1;
      #1 check("ar_gnt0", 32'(gnt), 0);
      check("ar_deq0", 32'(deq), 0);
      check("ar_vldo0", 32'(vldo), 0);
      check("ar_pkto0", 32'(pkto), 0);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ar_idle_gnt", 32'(gnt), 0);
      check("ar_idle_vldo", 32'(vldo), 0);
      vldi = '0;

      // All four ports request continuously with 2-flit packets.
      reqi = 4'hf; vldi = 4'hf;
      for (int p = 0; p < 4; p++) put(p, fl(HEAD, 16'h0100 + 16'(p)));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("arb_gnt%0d", k), 32'(gnt), 32'(1) << order[k]);
         @(negedge clk);
         check($sformatf("arb_head%0d", k), 32'(pkto), fl(HEAD, 16'h0100 + 16'(order[k])));
         put(order[k], fl(TAIL, 16'h0200 + 16'(order[k])));
         @(negedge clk);
         check($sformatf("arb_bubble%0d", k), 32'(gnt), 0);
         check($sformatf("arb_tail%0d", k), 32'(pkto), fl(TAIL, 16'h0200 + 16'(order[k])));
         put(order[k], fl(HEAD, 16'h0100 + 16'(order[k])));
      end
      reqi = '0; vldi = '0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
